// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: free-running fetch PC against a one-cycle-latency imem,
// buffering returned words with their PCs until the pipeline pops them.
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  output logic [31:0]      address_imem,
  input  logic [31:0]      q_imem,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [PTR_W:0]   occupancy
);

  logic [31:0]      fetch_pc;
  logic [31:0]      inflight_pc;
  logic             inflight;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [PTR_W+1:0] pending;

  // A redirect squashes both the head pop and the returning word in the same cycle
  assign pop  = instr_valid & instr_ready & ~redirect;
  assign push = inflight & ~redirect;

  // Slots already committed (queued + in flight) once this cycle's pop retires
  assign pending = {1'b0, count}
                 + {{(PTR_W+1){1'b0}}, inflight}
                 - {{(PTR_W+1){1'b0}}, instr_valid & instr_ready};
  assign issue   = ~redirect & (pending < (PTR_W+2)'(DEPTH));

  assign address_imem = fetch_pc;
  assign occupancy    = count;
  assign instr_valid  = (count != '0);
  assign instr        = instr_valid ? data_mem[rd_ptr] : 32'h0;
  assign instr_pc     = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= 32'h0;
      inflight_pc <= 32'h0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= q_imem;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed vector bench for fetch_prefetch_queue with a synchronous imem model (word = 0x1000 + address).
module tb_fetch_prefetch_queue;

  logic        clock;
  logic        reset;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  fetch_prefetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock),
    .reset(reset),
    .address_imem(address_imem),
    .q_imem(q_imem),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) q_imem <= 32'h1000 + address_imem;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [2:0]  occ;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(logic ready, logic redir, logic [31:0] rpc,
                              logic v, logic [31:0] pc, logic [2:0] occ, logic [31:0] addr);
    vec_t r;
    r.ready = ready; r.redir = redir; r.rpc = rpc;
    r.v = v; r.pc = pc; r.occ = occ; r.addr = addr;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic v, input logic [31:0] pc,
                             input logic [2:0] occ, input logic [31:0] addr);
    logic [31:0] exp_instr;
    exp_instr = v ? 32'h1000 + pc : 32'h0;
    chk("instr_valid", idx, {31'b0, instr_valid}, {31'b0, v});
    chk("instr_pc",    idx, instr_pc, v ? pc : 32'h0);
    chk("instr",       idx, instr, exp_instr);
    chk("occupancy",   idx, {29'b0, occupancy}, {29'b0, occ});
    chk("address_imem", idx, address_imem, addr);
    $display("step %0d: ready=%0b redirect=%0b rpc=%h -> valid=%0b pc=%h instr=%h occ=%0d addr=%h",
             idx, instr_ready, redirect, redirect_pc, instr_valid, instr_pc, instr, occupancy, address_imem);
  endtask

  initial begin
    // Stall from reset until full, release, then redirects including a double and a wrap
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 0, 1, 2);
    vecs[3]  = mk(0, 0, 0, 1, 0, 2, 3);
    vecs[4]  = mk(0, 0, 0, 1, 0, 3, 4);
    for (int i = 5; i <= 11; i++) vecs[i] = mk(0, 0, 0, 1, 0, 4, 4);
    vecs[12] = mk(1, 0, 0, 1, 0, 4, 4);
    vecs[13] = mk(1, 0, 0, 1, 1, 3, 5);
    vecs[14] = mk(1, 0, 0, 1, 2, 3, 6);
    vecs[15] = mk(1, 0, 0, 1, 3, 3, 7);
    vecs[16] = mk(1, 0, 0, 1, 4, 3, 8);
    vecs[17] = mk(1, 0, 0, 1, 5, 3, 9);
    vecs[18] = mk(1, 1, 32'h40, 1, 6, 3, 10);
    vecs[19] = mk(1, 0, 0, 0, 0, 0, 32'h40);
    vecs[20] = mk(1, 0, 0, 0, 0, 0, 32'h41);
    vecs[21] = mk(1, 0, 0, 1, 32'h40, 1, 32'h42);
    vecs[22] = mk(1, 0, 0, 1, 32'h41, 1, 32'h43);
    vecs[23] = mk(1, 1, 32'h20, 1, 32'h42, 1, 32'h44);
    vecs[24] = mk(1, 1, 32'h80, 0, 0, 0, 32'h20);
    vecs[25] = mk(1, 0, 0, 0, 0, 0, 32'h80);
    vecs[26] = mk(1, 0, 0, 0, 0, 0, 32'h81);
    vecs[27] = mk(1, 0, 0, 1, 32'h80, 1, 32'h82);
    vecs[28] = mk(1, 1, 32'hFFFF_FFFF, 1, 32'h81, 1, 32'h83);
    vecs[29] = mk(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    vecs[30] = mk(1, 0, 0, 0, 0, 0, 32'h0);
    vecs[31] = mk(1, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h1);
    vecs[32] = mk(1, 0, 0, 1, 32'h0, 1, 32'h2);
    vecs[33] = mk(1, 0, 0, 1, 32'h1, 1, 32'h3);

    reset = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(negedge clock);
    chk_outputs(-1, 0, 0, 0, 0);

    reset = 1'b1;
    for (int i = 0; i < 34; i++) begin
      instr_ready = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      #1;
      chk_outputs(i, vecs[i].v, vecs[i].pc, vecs[i].occ, vecs[i].addr);
      @(negedge clock);
    end

    // Asynchronous reset mid-cycle while the stream is running
    instr_ready = 1'b1;
    redirect = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_outputs(100, 0, 0, 0, 0);

    // Restart from PC 0 with the pipeline always ready
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k < 2) chk_outputs(200 + k, 0, 0, 0, k);
      else       chk_outputs(200 + k, 1, k - 2, 1, k);
      @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
